// File: rtl/vape_output_protection_multi.sv
// Output-protection monitor for an executable region (ER) guarding up to eight output regions.
// Optional macro VAPE_OR_CPU_WRITE_CHECK_EN enables CPU-write checking against the output regions.
module vape_output_protection_multi #(
  parameter int unsigned       ADDR_W        = 16,
  parameter int unsigned       NUM_OR        = 4,
  parameter logic [ADDR_W-1:0] RESET_HANDLER = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [ADDR_W-1:0]        data_addr,
  input  logic                     data_wr,
  input  logic [ADDR_W-1:0]        dma_addr,
  input  logic                     dma_en,
  input  logic [ADDR_W-1:0]        ER_min,
  input  logic [ADDR_W-1:0]        ER_max,
  input  logic [NUM_OR*ADDR_W-1:0] OR_min,
  input  logic [NUM_OR*ADDR_W-1:0] OR_max,
  output logic                     exec,
  output logic [2:0]               viol_cause,
  output logic [2:0]               viol_region,
  output logic [7:0]               viol_count
);

  typedef enum logic [1:0] {
    StAbort = 2'b00,
    StRun   = 2'b01,
    StDone  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              exec_q, exec_d;
  logic [2:0]        cause_q, cause_d;
  logic [2:0]        region_q, region_d;
  logic [7:0]        count_q, count_d;
  logic [ADDR_W-1:0] pc_prev_q;

  logic [NUM_OR-1:0] dma_match, cpu_match;
  logic [2:0]        match_idx;
  logic              hit_dma, hit_cpu;
  logic              pc_in_er, prev_in_er;
  logic              viol_wr, viol_cf;

  assign pc_in_er   = (pc >= ER_min) && (pc <= ER_max);
  assign prev_in_er = (pc_prev_q >= ER_min) && (pc_prev_q <= ER_max);

  // A region with min > max is disabled and never matches.
  always_comb begin
    dma_match = '0;
    cpu_match = '0;
    for (int i = 0; i < NUM_OR; i++) begin
      logic [ADDR_W-1:0] lo, hi;
      lo = OR_min[i*ADDR_W +: ADDR_W];
      hi = OR_max[i*ADDR_W +: ADDR_W];
      if (lo <= hi) begin
        dma_match[i] = dma_en && (dma_addr >= lo) && (dma_addr <= hi);
`ifdef VAPE_OR_CPU_WRITE_CHECK_EN
        cpu_match[i] = data_wr && !pc_in_er && (data_addr >= lo) && (data_addr <= hi);
`endif
      end
    end
  end

`ifndef VAPE_OR_CPU_WRITE_CHECK_EN
  logic unused_cpu;
  assign unused_cpu = ^{data_addr, data_wr};
`endif

  assign hit_dma = |dma_match;
  assign hit_cpu = |cpu_match;

  // Lowest matching index wins when regions overlap.
  always_comb begin
    match_idx = '0;
    for (int i = NUM_OR - 1; i >= 0; i--) begin
      if (dma_match[i] || cpu_match[i]) match_idx = 3'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    region_d = region_q;
    count_d  = count_q;
    viol_wr  = 1'b0;
    viol_cf  = 1'b0;
    if (pc == RESET_HANDLER) begin
      state_d = StAbort;
    end else if (hit_dma || hit_cpu) begin
      state_d = StAbort;
      viol_wr = (state_q == StRun) || (state_q == StDone);
    end else begin
      case (state_q)
        StAbort: begin
          if (pc == ER_min) begin
            state_d = StRun;
            cause_d = '0;
          end
        end
        StRun: begin
          if (!pc_in_er) begin
            if (pc_prev_q == ER_max) begin
              state_d = StDone;
            end else begin
              state_d = StAbort;
              viol_cf = 1'b1;
            end
          end else if ((pc == ER_min) && !prev_in_er) begin
            state_d = StAbort;
            viol_cf = 1'b1;
          end
        end
        StDone: begin
          if (pc == ER_min) state_d = StRun;
        end
        default: state_d = StAbort;
      endcase
    end
    if (viol_wr || viol_cf) begin
      cause_d = cause_q | {viol_cf, viol_wr && hit_cpu, viol_wr && hit_dma};
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
      if (viol_wr) region_d = match_idx;
    end
    exec_d = (state_d == StRun) || (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StAbort;
      exec_q    <= 1'b0;
      cause_q   <= '0;
      region_q  <= '0;
      count_q   <= '0;
      pc_prev_q <= RESET_HANDLER;
    end else begin
      state_q   <= state_d;
      exec_q    <= exec_d;
      cause_q   <= cause_d;
      region_q  <= region_d;
      count_q   <= count_d;
      pc_prev_q <= pc;
    end
  end

  assign exec        = exec_q;
  assign viol_cause  = cause_q;
  assign viol_region = region_q;
  assign viol_count  = count_q;

endmodule

// File: doc/vape_output_protection_multi.md
VAPE_OUTPUT_PROTECTION_MULTI -- requirements
Module: vape_output_protection_multi

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 16, address width of pc, data_addr, dma_addr and all region bounds.
  NUM_OR, 4, number of protected output regions (1..8).
  RESET_HANDLER, 16'h0000, pc value that forces ABORT.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, single system clock; all state updates on its rising edge.
  reset_n, in, 1, asynchronous active-low reset.
  pc, in, ADDR_W, current program counter.
  data_addr, in, ADDR_W, CPU data bus address.
  data_wr, in, 1, CPU write strobe.
  dma_addr, in, ADDR_W, DMA address.
  dma_en, in, 1, DMA write active.
  ER_min / ER_max, in, ADDR_W each, executable region bounds, inclusive.
  OR_min / OR_max, in, NUM_OR*ADDR_W each, packed region bounds, region i at bits [i*ADDR_W +: ADDR_W].
  exec, out, 1, proof-of-execution flag.
  viol_cause, out, 3, sticky cause: bit0 DMA, bit1 CPU, bit2 control flow.
  viol_region, out, 3, index of the region hit by the last write violation.
  viol_count, out, 8, saturating count of aborts caused by violations.

Function
REQ-003 Region i SHALL be enabled only when OR_min_i <= OR_max_i; a disabled region SHALL never match.
REQ-004 hit_dma SHALL be asserted when dma_en=1 and dma_addr lies inside any enabled region, bounds inclusive.
REQ-005 hit_cpu SHALL be asserted when data_wr=1, data_addr lies inside any enabled region, and pc lies outside [ER_min, ER_max].
REQ-006 The FSM SHALL be registered with three states: ABORT=2'b00, RUN=2'b01, DONE=2'b10; encoding 2'b11 SHALL return to ABORT.
REQ-007 Next-state priority SHALL be, highest first: pc==RESET_HANDLER -> ABORT; hit_dma or hit_cpu -> ABORT; the rules in REQ-008..REQ-010.
REQ-008 In ABORT, pc==ER_min SHALL move the FSM to RUN; otherwise it SHALL hold ABORT.
REQ-009 In RUN, when pc leaves [ER_min, ER_max]: if the previous-cycle pc equalled ER_max, the FSM SHALL move to DONE; otherwise it SHALL move to ABORT, a control-flow violation.
REQ-010 In RUN, pc==ER_min while pc_prev is outside ER SHALL move the FSM to ABORT, a re-entry violation counted as control flow. DONE SHALL hold until a REQ-007 event occurs, or until pc==ER_min, which moves it to RUN.
REQ-011 exec SHALL be a register equal to 1 exactly when the state is RUN or DONE, updated in the same edge as the state.
REQ-012 A violation abort SHALL be a transition from RUN/DONE to ABORT caused by hit_dma, hit_cpu or control flow. It SHALL:
  - OR the matching bits into viol_cause;
  - increment viol_count, saturating at 8'hFF;
  - load viol_region with the lowest matching region index. viol_region SHALL be unchanged for a control-flow-only abort.
REQ-013 An abort caused by pc==RESET_HANDLER SHALL NOT update viol_cause or viol_count. A write hit while already in ABORT SHALL NOT count.
REQ-014 Entry into RUN from ABORT SHALL clear viol_cause to 3'b000. viol_count and viol_region SHALL persist.
REQ-015 When pc==ER_min coincides with hit_dma in ABORT, the FSM SHALL remain in ABORT and the cycle SHALL NOT count.
REQ-016 pc_prev SHALL be a register of pc, reset to RESET_HANDLER.

Reset
REQ-017 When reset_n=0, asynchronously: state=ABORT, exec=0, viol_cause=0, viol_region=0, viol_count=0, pc_prev=RESET_HANDLER.
REQ-018 Reset asserted mid-RUN SHALL drop exec within the same reset assertion, with no count increment.

Configuration
REQ-019 With macro VAPE_OR_CPU_WRITE_CHECK_EN defined, hit_cpu SHALL be as in REQ-005. Without it, hit_cpu SHALL be constant 0, viol_cause[1] SHALL read 0, and the data_addr/data_wr inputs are unused.

Verification
REQ-020 The bench SHALL cover the following scenarios:
  - ER=[0x8000,0x80FF], pc 0x8000..0x80FF, then exit to 0x9000 -> exec=1 from the cycle after pc=0x8000 and stays 1 in DONE; viol_count=0.
  - RUN, dma_en=1, dma_addr=0x0300 inside region 2=[0x0300,0x030F] -> next edge exec=0, viol_cause=3'b001, viol_region=2, viol_count=1.
  - RUN, pc jumps from 0x8010 to 0x9000 -> exec=0, viol_cause=3'b100, viol_region unchanged.
  - Macro defined, DONE, pc=0x9000, data_wr=1, data_addr=0x0305 -> abort with viol_cause=3'b010. Macro undefined -> exec stays 1.
  - Region 1 with OR_min=0x0400, OR_max=0x03FF and DMA write to 0x0400 -> no abort. 300 forced violations -> viol_count=8'hFF.
  - reset_n pulsed low during RUN -> exec=0 immediately, all outputs zero; pc=ER_min after release re-arms RUN.
